// File: rtl/tc_pkg.sv
// Shared lamp codes and phase encoding for the traffic controller.
package tc_pkg;

    localparam logic [2:0] LAMP_RED = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b100;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GREEN     = 3'd1,
        YELLOW    = 3'd2,
        ALLRED    = 3'd3,
        EMRG_GO   = 3'd4,
        EMRG_HOLD = 3'd5
    } phase_e;

endpackage

// File: rtl/tc_rr_pick.sv
// Round-robin search: first approach with a sensor set,
// scanning upward from start and wrapping modulo N.
module tc_rr_pick #(
    parameter int N  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  sensor,
    input  logic [AW-1:0] start,
    output logic          found,
    output logic [AW-1:0] index
);

    // Scan downward so the nearest match to start is written last.
    always_comb begin
        found = 1'b0;
        index = start;
        for (int k = N - 1; k >= 0; k--) begin
            if (sensor[(int'(start) + k) % N]) begin
                found = 1'b1;
                index = AW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-approach traffic light controller with round-robin service,
// emergency pre-emption and registered collision alerts.
module traffic_ctrl_n
    import tc_pkg::*;
#(
    parameter int NUM_APPR   = 4,
    parameter int GREEN_MAX  = 30,
    parameter int GREEN_MIN  = 10,
    parameter int YELLOW_CYC = 5,
    parameter int ALLRED_CYC = 2,
    parameter int CNT_W      = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_APPR-1:0]         sensor,
    input  logic                        emrg,
    input  logic [$clog2(NUM_APPR)-1:0] emrg_dir,
    input  logic                        alert1,
    input  logic                        alert2,
    output logic [3*NUM_APPR-1:0]       light,
    output logic [$clog2(NUM_APPR)-1:0] active_appr,
    output logic [2:0]                  phase,
    output logic [CNT_W-1:0]            count,
    output logic                        ambulance,
    output logic                        police
);

    localparam int AW = $clog2(NUM_APPR);

    if (GREEN_MAX >= (1 << CNT_W)) begin : g_cnt_chk
        $error("CNT_W cannot hold GREEN_MAX");
    end
    if (NUM_APPR < 2 || NUM_APPR > 8) begin : g_appr_chk
        $error("NUM_APPR must be 2..8");
    end

    phase_e                phase_q, phase_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]         active_q, active_d;
    logic [AW-1:0]         edir_q, edir_d;
    logic                  pend_q, pend_d;
    logic [3*NUM_APPR-1:0] light_q, light_d;
    logic                  amb_q, amb_d;
    logic                  pol_q, pol_d;

    logic [AW-1:0] rr_start;
    logic [AW-1:0] rr_idx;
    logic          rr_found;

    // Idle resumes at the current approach; after clearance it moves on.
    always_comb begin
        rr_start = active_q;
        if (phase_q != IDLE) begin
            rr_start = (active_q == AW'(NUM_APPR - 1)) ? '0 : active_q + AW'(1);
        end
    end

    tc_rr_pick #(
        .N  (NUM_APPR),
        .AW (AW)
    ) u_pick (
        .sensor (sensor),
        .start  (rr_start),
        .found  (rr_found),
        .index  (rr_idx)
    );

    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        edir_d   = edir_q;
        pend_d   = pend_q;
        amb_d    = alert1 | alert2;
        pol_d    = alert1 | alert2;
        unique case (phase_q)
            IDLE: begin
                if (emrg) begin
                    phase_d  = EMRG_GO;
                    edir_d   = emrg_dir;
                    active_d = emrg_dir;
                end else if (rr_found) begin
                    phase_d  = GREEN;
                    active_d = rr_idx;
                end
            end
            GREEN: begin
                if (emrg && emrg_dir == active_q) begin
                    phase_d = EMRG_HOLD;
                end else if (emrg) begin
                    phase_d = YELLOW;
                    pend_d  = 1'b1;
                    edir_d  = emrg_dir;
                end else if (cnt_q == CNT_W'(GREEN_MAX) ||
                             (cnt_q >= CNT_W'(GREEN_MIN) && !sensor[active_q])) begin
                    phase_d = YELLOW;
                end
            end
            YELLOW, ALLRED: begin
                if (emrg && !pend_q) begin
                    pend_d = 1'b1;
                    edir_d = emrg_dir;
                end
                if (phase_q == YELLOW && cnt_q == CNT_W'(YELLOW_CYC)) begin
                    phase_d = ALLRED;
                end else if (phase_q == ALLRED && cnt_q == CNT_W'(ALLRED_CYC)) begin
                    if (pend_d) begin
                        phase_d  = EMRG_GO;
                        active_d = edir_d;
                        pend_d   = 1'b0;
                    end else if (rr_found) begin
                        phase_d  = GREEN;
                        active_d = rr_idx;
                    end else begin
                        phase_d = IDLE;
                    end
                end
            end
            EMRG_GO: phase_d = EMRG_HOLD;
            EMRG_HOLD: begin
                if (!emrg) phase_d = YELLOW;
            end
            default: phase_d = IDLE;
        endcase

        if (phase_d != phase_q || phase_q == IDLE) begin
            cnt_d = CNT_W'(1);
        end else if (phase_q == EMRG_HOLD && cnt_q == CNT_W'(GREEN_MAX)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        light_d = {NUM_APPR{LAMP_RED}};
        if (phase_d == GREEN || phase_d == EMRG_GO || phase_d == EMRG_HOLD) begin
            light_d[3*int'(active_d) +: 3] = LAMP_GRN;
        end else if (phase_d == YELLOW) begin
            light_d[3*int'(active_d) +: 3] = LAMP_YEL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= IDLE;
            cnt_q    <= CNT_W'(1);
            active_q <= '0;
            edir_q   <= '0;
            pend_q   <= 1'b0;
            light_q  <= {NUM_APPR{LAMP_RED}};
            amb_q    <= 1'b0;
            pol_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            edir_q   <= edir_d;
            pend_q   <= pend_d;
            light_q  <= light_d;
            amb_q    <= amb_d;
            pol_q    <= pol_d;
        end
    end

    assign light       = light_q;
    assign active_appr = active_q;
    assign phase       = phase_q;
    assign count       = cnt_q;
    assign ambulance   = amb_q;
    assign police      = pol_q;

endmodule
